// File: rtl/display_tx_fifo.sv
// display_tx_fifo: character queue between the CPU DSP register and the
// 40x24 text display. CPU writes are buffered in a small circular FIFO and
// replayed one at a time through the display's SETUP / STROBE / RELEASE
// handshake. Each character is followed by a gap with the display address
// held high, so the display's scroll line-clear writes can keep running.
module display_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       cpu_cs,
  input  logic       cpu_we,
  input  logic       cpu_addr,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  input  logic       flush,
  output logic       vga_address,
  output logic       vga_enable,
  output logic       vga_w_en,
  output logic [7:0] vga_din
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_RELEASE,
    ST_GAP
  } state_t;

  state_t state_reg, state_next;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic                  overflow_reg;
  logic [7:0]            gap_cnt_reg;
  logic [7:0]            din_reg;

  logic full;
  logic empty;
  logic push_req;
  logic push_ok;
  logic pop;
  logic load_head;

  // Full is judged on registered state, so a pop on the same edge never
  // makes room for a push. flush outranks any push in the same cycle.
  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  assign push_req  = cpu_cs & cpu_we & ~cpu_addr;
  assign push_ok   = push_req & ~full & ~flush;
  assign pop       = (state_reg == ST_STROBE) & ~flush;
  assign load_head = (state_next == ST_SETUP);

  // Character storage; no reset so it stays a plain RAM array.
  always_ff @(posedge clk25) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= cpu_din;
    end
  end

  // Queue pointers, occupancy count and sticky overflow flag.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
      end
      count_reg <= count_reg + CW'(push_ok) - CW'(pop);
      if (push_req && full) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic; flush always lands back in IDLE.
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:    if (!empty) state_next = ST_SETUP;
        ST_SETUP:   state_next = ST_STROBE;
        ST_STROBE:  state_next = ST_RELEASE;
        ST_RELEASE: state_next = ST_GAP;
        ST_GAP:     if (gap_cnt_reg == 8'd0) state_next = ST_IDLE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  // Gap counter: loaded on leaving RELEASE, counts GAP_CYCLES cycles of GAP.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      gap_cnt_reg <= 8'd0;
    end else if (flush) begin
      gap_cnt_reg <= 8'd0;
    end else if (state_reg == ST_RELEASE) begin
      gap_cnt_reg <= 8'(GAP_CYCLES - 1);
    end else if (state_reg == ST_GAP && gap_cnt_reg != 8'd0) begin
      gap_cnt_reg <= gap_cnt_reg - 8'd1;
    end
  end

  // Presented character: head of queue captured on entry to SETUP, then held.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      din_reg <= 8'h00;
    end else if (load_head) begin
      din_reg <= mem[rd_ptr_reg];
    end
  end

  // FSM outputs: address low only while a character is being handed over.
  always_comb begin
    vga_address = 1'b1;
    vga_enable  = 1'b0;
    vga_w_en    = 1'b0;
    case (state_reg)
      ST_SETUP:   vga_address = 1'b0;
      ST_STROBE: begin
        vga_address = 1'b0;
        vga_enable  = 1'b1;
        vga_w_en    = 1'b1;
      end
      ST_RELEASE: vga_address = 1'b0;
      default:    vga_address = 1'b1;
    endcase
  end

  assign vga_din = din_reg;

  // CPU read mux: busy bit at address 0, diagnostic status at address 1.
  logic [7:0] count_ext;
  logic [4:0] count_sat;

  assign count_ext = 8'(count_reg);
  assign count_sat = (count_ext > 8'd31) ? 5'd31 : count_ext[4:0];

  always_comb begin
    cpu_dout = 8'h00;
    if (cpu_cs && !cpu_we) begin
      if (!cpu_addr) begin
        cpu_dout = {full, 7'b0};
      end else begin
        cpu_dout = {overflow_reg, empty, 1'b0, count_sat};
      end
    end
  end

endmodule
